spi_mem_ctrl: RTL and testbench
===============================

// Module: spi_mem_ctrl
// PURPOSE
// - Host-side transaction controller that drives spi_mem's serial pins.
// - Accepts byte read/write requests on a valid/ready interface and serialises them onto cs/miso.
// - Collects read data from mosi, qualified by ready, and returns a one-cycle response on op_done.
// - Sits directly upstream of spi_mem; both blocks share clk and rst.
// PARAMETERS
// - MEM_DEPTH       32  number of valid addresses; req_addr >= MEM_DEPTH is rejected
// - TIMEOUT_CYCLES  64  watchdog limit, used only with SPI_CTRL_TIMEOUT_EN
// PORTS
// - clk          in   1  clock, rising edge
// - rst          in   1  reset, synchronous, active-high
// - req_valid    in   1  request present
// - req_ready    out  1  controller can accept; high only in IDLE
// - req_wr       in   1  1 = write, 0 = read
// - req_addr     in   8  byte address
// - req_wdata    in   8  write data
// - rsp_valid    out  1  one-cycle response pulse
// - rsp_rdata    out  8  read data; 0 for writes and errors
// - rsp_err      out  1  qualified by rsp_valid; address out of range, or timeout
// - mem_cs       out  1  to spi_mem.cs, active-low
// - mem_miso     out  1  to spi_mem.miso: mode bit, then payload, LSB first
// - mem_mosi     in   1  from spi_mem.mosi: read data, LSB first
// - mem_ready    in   1  from spi_mem.ready: read data valid
// - mem_op_done  in   1  from spi_mem.op_done: transaction complete
// BEHAVIOUR
// - Reset values: mem_cs=1, mem_miso=0, req_ready=0 during reset (1 once in IDLE),
//   rsp_valid=0, rsp_rdata=0, rsp_err=0; FSM goes to IDLE.
// - Outputs are registered; all counters are cleared.
// - Accept: req_valid & req_ready at edge A latches wr, addr and wdata.
// - Range check: if req_addr >= MEM_DEPTH, go straight to RESP.
//   rsp_valid=1 and rsp_err=1 after edge A+1; no SPI activity.
// - SETUP: mem_cs=0 and mem_miso=req_wr from edge A; held for 2 cycles.
// - At edge A+2: mem_cs=1, mem_miso=payload bit 0.
// - SHIFT: one bit per cycle, LSB first.
//   - Write: 16 bits, {wdata, addr} (addr[0] first, wdata[7] last).
//   - Read: 8 bits, addr only.
// - After the last bit: mem_miso=0.
// - Write then goes to WAIT_DONE.
// - Read then goes to WAIT_RDY: wait for mem_ready=1.
// - CAPTURE: sample mem_mosi into rdata[i] on 8 consecutive edges, starting with the first edge
//   where mem_ready=1; i=0..7.
// - CAPTURE then goes to WAIT_DONE.
// - WAIT_DONE: on the edge where mem_op_done=1, enter RESP.
// - RESP: one cycle with rsp_valid=1, rsp_rdata=rdata (read) or 0 (write), rsp_err=0; then IDLE.
// - req_ready=0 in RESP, so back-to-back requests have a 1-cycle gap.
// - Nominal latency, edge A to rsp_valid high: write 20 cycles, read 21 cycles.
//   The FSM is handshake-driven, not count-driven.
// - mem_cs is never low outside SETUP. This prevents spi_mem restarting when it returns to idle.
// - mem_op_done or mem_ready outside WAIT_DONE/WAIT_RDY is ignored.
// - Reset mid-transaction: abort to IDLE; no rsp_valid is issued for the aborted request.
// CONFIGURATION
// - SPI_CTRL_TIMEOUT_EN defined:
//   - A counter runs in WAIT_RDY and WAIT_DONE.
//   - If it reaches TIMEOUT_CYCLES without the awaited signal, enter RESP with
//     rsp_err=1 and rsp_rdata=0, then IDLE.
//   - The counter clears on each state entry.
// - SPI_CTRL_TIMEOUT_EN undefined:
//   - No counter; the FSM waits indefinitely in WAIT_RDY/WAIT_DONE.
//   - rsp_err is asserted only for range errors.
// TESTING
// - Write addr=0x05, wdata=0xA5 -> mem_cs low exactly 2 cycles;
//   mem_miso shows 1, then 1,0,1,0,0,0,0,0,1,0,1,0,0,1,0,1;
//   rsp_valid 20 cycles after accept, rsp_err=0.
// - Read addr=0x05 after that write -> 8 addr bits 1,0,1,0,0,0,0,0;
//   rsp_rdata=0xA5 21 cycles after accept.
// - Read addr=0x1F of unwritten memory -> rsp_rdata=0x00.
//   Write 0x3C to 0x1F, then read -> 0x3C.
// - Request addr=0x20 -> rsp_err=1 one cycle after accept; mem_cs stays 1; spi_mem state unchanged.
// - Back-to-back: write 0x11 to 0x02, then read 0x02 held valid -> second accept exactly 1 cycle
//   after the first rsp_valid; rsp_rdata=0x11.
// - rst pulse mid-SHIFT -> mem_cs=1, mem_miso=0, no rsp_valid.
//   Next read of 0x05 returns the pre-abort value.
// - With SPI_CTRL_TIMEOUT_EN: tie mem_op_done=0 -> rsp_err=1 after TIMEOUT_CYCLES in WAIT_DONE.

Source files
------------

// File: rtl/spi_mem_ctrl.sv
// Host-side controller that turns byte read/write requests into spi_mem pin activity.
// Optional watchdog on the handshake waits: define SPI_CTRL_TIMEOUT_EN.
module spi_mem_ctrl #(
  parameter int MEM_DEPTH      = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_wr,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       mem_cs,
  output logic       mem_miso,
  input  logic       mem_mosi,
  input  logic       mem_ready,
  input  logic       mem_op_done
);

  typedef enum logic [2:0] {
    IDLE, SETUP, SHIFT, WAIT_RDY, CAPTURE, WAIT_DONE, RESP
  } state_t;

  localparam logic [8:0] DEPTH9 = 9'(MEM_DEPTH);

  state_t      state;
  logic        wr_q;
  logic [15:0] shreg;
  logic [7:0]  rdata;
  logic [4:0]  cnt;
  logic [4:0]  nbits;
  logic        addr_bad;
  logic        tmo;

  assign nbits    = wr_q ? 5'd16 : 5'd8;
  assign addr_bad = ({1'b0, req_addr} >= DEPTH9);

`ifdef SPI_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;

  assign tmo = (tcnt == TW'(TIMEOUT_CYCLES - 1));

  // Runs only while stalled in a wait state; any other cycle clears it, so each entry starts at 0.
  always_ff @(posedge clk) begin
    if (rst)
      tcnt <= '0;
    else if (((state == WAIT_RDY && !mem_ready) || (state == WAIT_DONE && !mem_op_done)) && !tmo)
      tcnt <= tcnt + 1'b1;
    else
      tcnt <= '0;
  end
`else
  // No watchdog: the waits never expire.
  assign tmo = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      rsp_err   <= 1'b0;
      mem_cs    <= 1'b1;
      mem_miso  <= 1'b0;
      cnt       <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            wr_q      <= req_wr;
            shreg     <= {req_wdata, req_addr};
            cnt       <= 5'd0;
            if (addr_bad) begin
              state <= RESP;
            end else begin
              state    <= SETUP;
              mem_cs   <= 1'b0;
              mem_miso <= req_wr;
            end
          end
        end
        SETUP: begin
          if (cnt == 5'd0) begin
            cnt <= 5'd1;
          end else begin
            mem_cs   <= 1'b1;
            mem_miso <= shreg[0];
            shreg    <= {1'b0, shreg[15:1]};
            cnt      <= 5'd1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt == nbits) begin
            mem_miso <= 1'b0;
            cnt      <= 5'd0;
            state    <= wr_q ? WAIT_DONE : WAIT_RDY;
          end else begin
            mem_miso <= shreg[0];
            shreg    <= {1'b0, shreg[15:1]};
            cnt      <= cnt + 5'd1;
          end
        end
        WAIT_RDY: begin
          if (mem_ready) begin
            rdata <= {mem_mosi, rdata[7:1]};
            cnt   <= 5'd1;
            state <= CAPTURE;
          end else if (tmo) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= 8'h00;
          end
        end
        CAPTURE: begin
          // LSB arrives first, so shift in from the top; eight samples leave it in bit 0.
          rdata <= {mem_mosi, rdata[7:1]};
          cnt   <= cnt + 5'd1;
          if (cnt == 5'd7)
            state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (mem_op_done) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= wr_q ? 8'h00 : rdata;
          end else if (tmo) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= 8'h00;
          end
        end
        RESP: begin
          // Range errors arrive here with rsp_valid still low and spend one extra cycle raising it.
          if (rsp_valid) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 8'h00;
            req_ready <= 1'b1;
            state     <= IDLE;
          end else begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= 8'h00;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Self-checking bench for spi_mem_ctrl; the bench itself plays spi_mem from a byte-array model.
module tb_spi_mem_ctrl;

  localparam int MEM_DEPTH      = 32;
  localparam int TIMEOUT_CYCLES = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_wr;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       mem_cs;
  logic       mem_miso;
  logic       mem_mosi;
  logic       mem_ready;
  logic       mem_op_done;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem [0:MEM_DEPTH-1];

  spi_mem_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_wr      (req_wr),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .mem_cs      (mem_cs),
    .mem_miso    (mem_miso),
    .mem_mosi    (mem_mosi),
    .mem_ready   (mem_ready),
    .mem_op_done (mem_op_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_rsp_low", 32'(rsp_valid), 32'd0);
      chk("idle_cs_high", 32'(mem_cs), 32'd1);
    end
  endtask

  // One request end to end. Time t counts negedges after the accept edge; at negedge t the bench
  // sees what the DUT registered at edge t and drives what the DUT samples at edge t+1.
  task automatic txn(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                     input int d, input bit no_done, output int waited);
    bit          ok;
    bit          got;
    logic [15:0] pl;
    logic [7:0]  exp_rd;
    logic        exp_cs;
    logic        exp_mi;
    int          nb;
    int          lat;
    int          exp_lat;
    ok      = (int'(addr) < MEM_DEPTH);
    exp_rd  = (ok && !wr) ? mem[addr[4:0]] : 8'h00;
    pl      = {wdata, addr};
    nb      = wr ? 16 : 8;
    if (!ok)          exp_lat = 1;
    else if (no_done) exp_lat = (wr ? 18 : 10) + TIMEOUT_CYCLES;
    else              exp_lat = (wr ? 20 : 21) + d;

    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wdata;
    waited    = 0;
    while (!req_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    chk("accept_ready", 32'(req_ready), 32'd1);
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    req_valid = 1'b0;

    got = 1'b0;
    lat = -1;
    for (int t = 0; t < 200 && !got; t++) begin
      if (t > 0) @(negedge clk);
      mem_mosi    = 1'($urandom);
      mem_ready   = 1'b0;
      mem_op_done = 1'b0;
      if (ok && !no_done) begin
        if (!wr && t >= 12 + d && t < 20 + d) begin
          mem_ready = 1'b1;
          mem_mosi  = exp_rd[3'(t - 12 - d)];
        end
        if (t == (wr ? 19 : 20) + d) mem_op_done = 1'b1;
      end
      if (ok && t == 4) mem_op_done = 1'b1;
      if (rsp_valid) begin
        got = 1'b1;
        lat = t;
      end else if (ok) begin
        exp_cs = (t < 2) ? 1'b0 : 1'b1;
        if (t < 2)           exp_mi = wr;
        else if (t < 2 + nb) exp_mi = pl[4'(t - 2)];
        else                 exp_mi = 1'b0;
        chk($sformatf("cs_t%0d", t), 32'(mem_cs), 32'(exp_cs));
        chk($sformatf("miso_t%0d", t), 32'(mem_miso), 32'(exp_mi));
      end else begin
        chk("range_err_cs_high", 32'(mem_cs), 32'd1);
      end
    end
    mem_ready   = 1'b0;
    mem_op_done = 1'b0;

    chk($sformatf("rsp_seen a=%0h", addr), 32'(got), 32'd1);
    chk($sformatf("latency a=%0h wr=%0d", addr, wr), 32'(lat), 32'(exp_lat));
    chk($sformatf("rsp_err a=%0h", addr), 32'(rsp_err), 32'(!ok || no_done));
    chk($sformatf("rsp_rdata a=%0h", addr), 32'(rsp_rdata),
        (ok && !wr && !no_done) ? 32'(exp_rd) : 32'd0);
    if (ok && wr && !no_done) mem[addr[4:0]] = wdata;
  endtask

  initial begin
    int w;
    rst         = 1'b1;
    req_valid   = 1'b0;
    req_wr      = 1'b0;
    req_addr    = 8'h00;
    req_wdata   = 8'h00;
    mem_mosi    = 1'b0;
    mem_ready   = 1'b0;
    mem_op_done = 1'b0;
    for (int i = 0; i < MEM_DEPTH; i++) mem[i] = 8'h00;

    repeat (3) @(negedge clk);
    chk("rst_cs",        32'(mem_cs),    32'd1);
    chk("rst_miso",      32'(mem_miso),  32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_rsp_err",   32'(rsp_err),   32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", 32'(req_ready), 32'd1);

    txn(1'b1, 8'h05, 8'hA5, 0, 1'b0, w);
    idle(1);
    txn(1'b0, 8'h05, 8'h00, 0, 1'b0, w);
    idle(2);
    txn(1'b0, 8'h1F, 8'h00, 0, 1'b0, w);
    idle(1);
    txn(1'b1, 8'h1F, 8'h3C, 0, 1'b0, w);
    idle(1);
    txn(1'b0, 8'h1F, 8'h00, 2, 1'b0, w);
    idle(1);
    txn(1'b1, 8'h20, 8'h99, 0, 1'b0, w);
    idle(2);
    txn(1'b0, 8'h05, 8'h00, 0, 1'b0, w);
    idle(1);

    txn(1'b1, 8'h02, 8'h11, 0, 1'b0, w);
    txn(1'b0, 8'h02, 8'h00, 0, 1'b0, w);
    chk("b2b_gap", 32'(w), 32'd1);
    idle(1);

    // Abort a write of 0x05 partway through its payload.
    req_valid = 1'b1;
    req_wr    = 1'b1;
    req_addr  = 8'h05;
    req_wdata = 8'h5A;
    chk("abort_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_shift_cs", 32'(mem_cs), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_cs",        32'(mem_cs),    32'd1);
    chk("abort_miso",      32'(mem_miso),  32'd0);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    idle(25);
    txn(1'b0, 8'h05, 8'h00, 1, 1'b0, w);
    idle(1);

    for (int k = 0; k < 24; k++) begin
      txn(1'($urandom_range(0, 1)), 8'($urandom_range(0, 39)), 8'($urandom),
          int'($urandom_range(0, 3)), 1'b0, w);
      idle(int'($urandom_range(1, 3)));
    end

`ifdef SPI_CTRL_TIMEOUT_EN
    txn(1'b1, 8'h03, 8'h77, 0, 1'b1, w);
    idle(1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
